mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer for the NPC core. Shares one downstream memory port (the DPI `pmem_read`/`pmem_write` wrapper) between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one transaction at a time and arbitrates round-robin.
- Sequences request, wait and response phases through a 4-state FSM.
- Returns an error response if the memory fails to answer within a bounded number of cycles.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_if.sv | 54 +++++
 rtl/mem_arb_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the NPC memory arbiter.
//   state_t    : arbiter FSM states
//   OWN_*      : transaction owner encoding
//   MASK_*     : byte-mask encodings for 8/16/32/64-bit accesses
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of every handshake/bus signal around the arbiter.
//   ifu_*  : instruction-fetch request/response (read-only)
//   lsu_*  : load/store request/response
//   mem_*  : single downstream memory port
// Modports:
//   slave  : arbiter view (requests and memory responses in)
//   master : environment view (requesters and memory model)
interface mem_arb_if #(
  parameter int XLEN = 64
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_resp_valid;
  logic [XLEN-1:0] ifu_resp_data;
  logic            ifu_resp_err;

  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [XLEN-1:0] lsu_req_addr;
  logic            lsu_req_wen;
  logic [XLEN-1:0] lsu_req_wdata;
  logic [7:0]      lsu_req_mask;
  logic            lsu_resp_valid;
  logic [XLEN-1:0] lsu_resp_data;
  logic            lsu_resp_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_wen;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_mask;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_mask,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_mask,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: 8-bit saturating transaction timer.
//   clk, rst  : clock, async active-high reset
//   i_clr     : restart count at 0 (wins over i_en)
//   i_en      : count up one per cycle, saturating at 255
//   o_expired : count has reached TIMEOUT_CYC-1
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_en && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
  end

  // >= rather than == so a REQ->WAIT hop on the expiry cycle still
  // times out in WAIT instead of running past the limit.
  assign o_expired = (r_cnt >= LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU (read) and LSU (read/write).
// One transaction at a time, round-robin on conflict, IDLE->REQ->WAIT->RESP,
// bounded by a timeout that returns err=1 with zero data.
//   clk, rst : clock, async active-high reset (drops any in-flight transaction)
//   bus      : mem_arb_if.slave carrying IFU, LSU and memory handshakes
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         XLEN        = 64,
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] IFU_MASK    = MASK_W
) (
  input logic     clk,
  input logic     rst,
  mem_arb_if.slave bus
);
  state_t          r_state;
  logic            r_owner, r_last_owner;
  logic [XLEN-1:0] r_req_addr, r_req_wdata, r_resp_data;
  logic            r_req_wen, r_resp_err;
  logic [7:0]      r_req_mask;

  logic w_idle, w_gnt_ifu, w_gnt_lsu, w_expired, w_resp_ifu, w_resp_lsu;

  // Conflict goes to whoever did not own the previous transaction.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_gnt_ifu = w_idle && bus.ifu_req_valid &&
                     (!bus.lsu_req_valid || r_last_owner == OWN_LSU);
  assign w_gnt_lsu = w_idle && bus.lsu_req_valid &&
                     (!bus.ifu_req_valid || r_last_owner == OWN_IFU);

  mem_arb_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_gnt_ifu | w_gnt_lsu),
    .i_en      (r_state == ST_REQ || r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IFU;
      r_last_owner <= OWN_IFU;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_req_wen    <= 1'b0;
      r_req_mask   <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_lsu) begin
            r_req_addr   <= bus.lsu_req_addr;
            r_req_wdata  <= bus.lsu_req_wdata;
            r_req_wen    <= bus.lsu_req_wen;
            r_req_mask   <= bus.lsu_req_mask;
            r_owner      <= OWN_LSU;
            r_last_owner <= OWN_LSU;
            r_state      <= ST_REQ;
          end else if (w_gnt_ifu) begin
            r_req_addr   <= bus.ifu_req_addr;
            r_req_wdata  <= '0;
            r_req_wen    <= 1'b0;
            r_req_mask   <= IFU_MASK;
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_IFU;
            r_state      <= ST_REQ;
          end
        end
        // Progress beats timeout when both happen in the same cycle.
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            r_state <= ST_WAIT;
          end else if (w_expired) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_resp_data <= r_req_wen ? '0 : bus.mem_resp_data;
            r_resp_err  <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_expired) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_resp_ifu = (r_state == ST_RESP) && (r_owner == OWN_IFU);
  assign w_resp_lsu = (r_state == ST_RESP) && (r_owner == OWN_LSU);

  assign bus.ifu_req_ready  = w_gnt_ifu;
  assign bus.lsu_req_ready  = w_gnt_lsu;

  assign bus.mem_req_valid  = (r_state == ST_REQ);
  assign bus.mem_req_addr   = r_req_addr;
  assign bus.mem_req_wen    = r_req_wen;
  assign bus.mem_req_wdata  = r_req_wdata;
  assign bus.mem_req_mask   = r_req_mask;

  // Response payload only shows on the owner's side while its strobe is up.
  assign bus.ifu_resp_valid = w_resp_ifu;
  assign bus.ifu_resp_data  = w_resp_ifu ? r_resp_data : '0;
  assign bus.ifu_resp_err   = w_resp_ifu & r_resp_err;
  assign bus.lsu_resp_valid = w_resp_lsu;
  assign bus.lsu_resp_data  = w_resp_lsu ? r_resp_data : '0;
  assign bus.lsu_resp_err   = w_resp_lsu & r_resp_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT_CYC=8).
// Inputs change and outputs are sampled one time unit after the falling edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_arb_if #(.XLEN(XLEN)) bus ();

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYC(8), .IFU_MASK(MASK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid,
                            bus.mem_req_wen, bus.ifu_resp_valid, bus.lsu_resp_valid,
                            bus.ifu_resp_err, bus.lsu_resp_err}), 64'h0);
    chk({tag, "_maddr"}, bus.mem_req_addr, 64'h0);
    chk({tag, "_mwdata"}, bus.mem_req_wdata, 64'h0);
    chk({tag, "_mmask"}, 64'(bus.mem_req_mask), 64'h0);
    chk({tag, "_rdata"}, bus.ifu_resp_data | bus.lsu_resp_data, 64'h0);
  endtask

  // One full transaction with immediate memory; entered and left in IDLE.
  task automatic run_txn(input string tag, input logic exp_lsu, input logic [63:0] rdata);
    settle();
    chk({tag, "_ifu_rdy"}, 64'(bus.ifu_req_ready), 64'(!exp_lsu));
    chk({tag, "_lsu_rdy"}, 64'(bus.lsu_req_ready), 64'(exp_lsu));
    bus.mem_req_ready = 1'b1;
    nxt(); settle();
    chk({tag, "_mvalid"}, 64'(bus.mem_req_valid), 64'h1);
    chk({tag, "_mmask"}, 64'(bus.mem_req_mask), exp_lsu ? 64'h03 : 64'h0F);
    chk({tag, "_busy_rdy"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'h0);
    nxt();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rdata;
    nxt();
    bus.mem_resp_valid = 1'b0;
    settle();
    chk({tag, "_ifu_rv"}, 64'(bus.ifu_resp_valid), 64'(!exp_lsu));
    chk({tag, "_lsu_rv"}, 64'(bus.lsu_resp_valid), 64'(exp_lsu));
    chk({tag, "_rdata"}, exp_lsu ? bus.lsu_resp_data : bus.ifu_resp_data, rdata);
    chk({tag, "_resp_rdy"}, 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'h0);
    nxt();
  endtask

  initial begin
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_mask   = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    #2 chk_zero("reset");
    nxt(); rst = 1'b0;
    nxt();

    // IFU read, immediate memory
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0000;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("ifu_rd_rdy", 64'(bus.ifu_req_ready), 64'h1);
    chk("ifu_rd_lsu_rdy", 64'(bus.lsu_req_ready), 64'h0);
    nxt(); bus.ifu_req_valid = 1'b0; settle();
    chk("ifu_rd_mvalid", 64'(bus.mem_req_valid), 64'h1);
    chk("ifu_rd_maddr", bus.mem_req_addr, 64'h8000_0000);
    chk("ifu_rd_mmask", 64'(bus.mem_req_mask), 64'h0F);
    chk("ifu_rd_mwen", 64'(bus.mem_req_wen), 64'h0);
    chk("ifu_rd_mwdata", bus.mem_req_wdata, 64'h0);
    nxt();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0000_0000_0010_0093;
    settle();
    chk("ifu_rd_wait_mvalid", 64'(bus.mem_req_valid), 64'h0);
    nxt(); bus.mem_resp_valid = 1'b0; settle();
    chk("ifu_rd_rv", 64'(bus.ifu_resp_valid), 64'h1);
    chk("ifu_rd_data", bus.ifu_resp_data, 64'h0000_0000_0010_0093);
    chk("ifu_rd_err", 64'(bus.ifu_resp_err), 64'h0);
    chk("ifu_rd_lsu_rv", 64'(bus.lsu_resp_valid), 64'h0);
    nxt(); settle();
    chk("ifu_rd_rv_once", 64'(bus.ifu_resp_valid), 64'h0);

    // LSU store
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b1;
    bus.lsu_req_addr  = 64'h8000_1000;
    bus.lsu_req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    bus.lsu_req_mask  = 8'hFF;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("st_rdy", 64'(bus.lsu_req_ready), 64'h1);
    nxt(); bus.lsu_req_valid = 1'b0; settle();
    chk("st_maddr", bus.mem_req_addr, 64'h8000_1000);
    chk("st_mwdata", bus.mem_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("st_mmask", 64'(bus.mem_req_mask), 64'hFF);
    chk("st_mwen", 64'(bus.mem_req_wen), 64'h1);
    nxt();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h5555_AAAA_5555_AAAA;
    nxt(); bus.mem_resp_valid = 1'b0; settle();
    chk("st_rv", 64'(bus.lsu_resp_valid), 64'h1);
    chk("st_data", bus.lsu_resp_data, 64'h0);
    chk("st_err", 64'(bus.lsu_resp_err), 64'h0);
    chk("st_ifu_rv", 64'(bus.ifu_resp_valid), 64'h0);
    nxt();
    bus.lsu_req_wen = 1'b0;

    // Back-pressure: mem_req_ready low for 5 REQ cycles
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_0040;
    settle();
    chk("bp_rdy", 64'(bus.ifu_req_ready), 64'h1);
    nxt(); bus.ifu_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_mvalid", 64'(bus.mem_req_valid), 64'h1);
      chk("bp_maddr", bus.mem_req_addr, 64'h8000_0040);
      chk("bp_mmask", 64'(bus.mem_req_mask), 64'h0F);
      chk("bp_no_rv", 64'(bus.ifu_resp_valid), 64'h0);
      nxt();
    end
    bus.mem_req_ready = 1'b1;
    settle();
    chk("bp_mvalid_last", 64'(bus.mem_req_valid), 64'h1);
    nxt();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0000_0000_00A0_0513;
    settle();
    chk("bp_wait_rv", 64'(bus.ifu_resp_valid), 64'h0);
    nxt(); bus.mem_resp_valid = 1'b0; settle();
    chk("bp_rv", 64'(bus.ifu_resp_valid), 64'h1);
    chk("bp_data", bus.ifu_resp_data, 64'h0000_0000_00A0_0513);
    nxt();

    // Timeout: LSU load, memory accepts but never answers
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_2000;
    bus.lsu_req_mask  = 8'h0F;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("to_rdy", 64'(bus.lsu_req_ready), 64'h1);
    nxt(); bus.lsu_req_valid = 1'b0; settle();
    chk("to_no_rv", 64'(bus.lsu_resp_valid), 64'h0);
    nxt(); bus.mem_req_ready = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      settle();
      chk("to_no_rv", 64'(bus.lsu_resp_valid), 64'h0);
      nxt();
    end
    settle();
    chk("to_rv", 64'(bus.lsu_resp_valid), 64'h1);
    chk("to_err", 64'(bus.lsu_resp_err), 64'h1);
    chk("to_data", bus.lsu_resp_data, 64'h0);
    nxt();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0BAD;
    settle();
    chk("late_rv", 64'(bus.lsu_resp_valid), 64'h0);
    chk("late_mvalid", 64'(bus.mem_req_valid), 64'h0);
    nxt(); bus.mem_resp_valid = 1'b0; settle();
    chk("late_rv2", 64'({bus.lsu_resp_valid, bus.ifu_resp_valid}), 64'h0);

    // Reset while in WAIT
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_3000;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("rst_txn_rdy", 64'(bus.ifu_req_ready), 64'h1);
    nxt(); bus.ifu_req_valid = 1'b0;
    nxt();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    settle();
    chk_zero("rst_async");
    nxt();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h77;
    settle();
    chk_zero("rst_after");
    nxt(); bus.mem_resp_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("rst_no_rv", 64'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 64'h0);
      nxt();
    end

    // Contention from reset: LSU, IFU, LSU, IFU
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = 64'h8000_4000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_addr  = 64'h8000_5000;
    bus.lsu_req_mask  = 8'h03;
    run_txn("cont0", 1'b1, 64'h1111);
    run_txn("cont1", 1'b0, 64'h2222);
    run_txn("cont2", 1'b1, 64'h3333);
    run_txn("cont3", 1'b0, 64'h4444);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
